gate2_sweep_checker: RTL
========================

GATE2_SWEEP_CHECKER -- requirements
Module: gate2_sweep_checker

Interface
REQ-001 SHALL have parameter TRUTH, default 4'b0001, expected nq per vector index {i1,i0} (bit n = expected nq for vector n; default is the NOR2 truth table).
REQ-002 SHALL have parameter SETTLE, default 2, range 1..15, the number of cycles a vector is held before nq is sampled.
REQ-003 SHALL have parameter LOOPS, default 1, range 1..255, the number of full 4-vector sweeps per run.
REQ-004 SHALL have port ck, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit; a run request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit; terminates a run in progress.
REQ-008 SHALL have port nq, input, 1 bit; the response of the 2-input cell under test, combinationally driven from i0/i1.
REQ-009 SHALL have ports i0 and i1, each an output of 1 bit; the registered stimulus to the cell under test.
REQ-010 SHALL have port busy, output, 1 bit; high while in any state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit; a one-cycle pulse at normal run completion.
REQ-012 SHALL have port pass, output, 1 bit; valid from done until the next accepted start.
REQ-013 SHALL have port err_cnt, output, 8 bits; the mismatch count, saturating.
REQ-014 SHALL have port fail_vec, output, 4 bits; a sticky per-vector mismatch flag, bit n = vector n.

Function
REQ-015 SHALL implement the states IDLE, HOLD, SAMPLE and FINISH.
REQ-016 IDLE with start=1 SHALL, on the next edge, perform all of: busy=1, vector v=0 (i1=0, i0=0), hold counter=0, loop counter=0, err_cnt=0, fail_vec=0, pass=0, and enter HOLD.
REQ-017 HOLD SHALL keep i0=v[0] and i1=v[1] stable and increment the hold counter each cycle; after SETTLE cycles in HOLD it SHALL enter SAMPLE.
REQ-018 SAMPLE SHALL last exactly one cycle; at its end the block SHALL compare nq against TRUTH[v].
REQ-019 On a SAMPLE mismatch, err_cnt SHALL increment, saturating at 255 with no wrap, and fail_vec[v] SHALL be set.
REQ-020 On leaving SAMPLE with v<3, v SHALL increment, the new i0/i1 SHALL be registered on the same edge, the hold counter SHALL clear, and the block SHALL return to HOLD.
REQ-021 On leaving SAMPLE with v=3, v SHALL wrap to 0 and the loop counter SHALL increment; if the loop count now equals LOOPS the block SHALL enter FINISH, otherwise it SHALL return to HOLD.
REQ-022 Each vector SHALL cost exactly SETTLE+1 cycles, so the run length from the start-accept edge to the FINISH entry edge is LOOPS*4*(SETTLE+1) cycles.
REQ-023 FINISH SHALL last one cycle, with done=1, pass=(err_cnt==0), i0=i1=0, then return to IDLE.
REQ-024 busy SHALL stay high in FINISH and fall in the IDLE cycle that follows.
REQ-025 start while busy=1 SHALL be ignored with no effect on state or counters.
REQ-026 start held high across FINISH SHALL begin a new run only from the first IDLE cycle.
REQ-027 abort=1 in HOLD or SAMPLE SHALL, on the next edge, force IDLE, i0=i1=0, done=0 and pass=0, with err_cnt and fail_vec retaining their values.
REQ-028 abort in IDLE or FINISH SHALL be ignored; in FINISH, done and pass complete normally.
REQ-029 When abort and the final SAMPLE coincide, abort SHALL take priority: no done pulse and pass=0.
REQ-030 nq SHALL be sampled only in SAMPLE; its value in every other state SHALL have no effect.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, i0=0, i1=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, and all internal counters=0.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 rst asserted mid-run SHALL abandon the run with no done pulse; the first post-reset cycle SHALL be IDLE.
REQ-034 Outputs SHALL remain at their reset values for as long as rst stays high.

Verification
REQ-035 SHALL cover this scenario: defaults, a correct NOR2 model on nq, start pulse -> i1i0 sequence 00,01,10,11 each held 3 cycles, done at cycle 12, pass=1, err_cnt=0, fail_vec=0.
REQ-036 SHALL cover this scenario: defaults with nq stuck at 0 -> done at 12, pass=0, err_cnt=1, fail_vec=4'b0001.
REQ-037 SHALL cover this scenario: LOOPS=255, SETTLE=1, nq stuck at 1 -> err_cnt saturates at 255 (765 mismatches), fail_vec=4'b1110, pass=0, done at 2040.
REQ-038 SHALL cover this scenario: defaults with abort asserted during vector 2 HOLD -> IDLE next edge, no done, i0=i1=0, fail_vec holds the bits captured so far.
REQ-039 SHALL cover this scenario: rst pulse during SAMPLE of vector 1 -> all outputs 0 next cycle; a subsequent start runs a full sweep from vector 0.
REQ-040 SHALL cover this scenario: start held high continuously for 30 cycles -> back-to-back runs with exactly one IDLE cycle between FINISH and the next HOLD, and no start acceptance while busy.

Source files
------------

// File: rtl/gate2_sweep_checker.sv
// Sweeps all four input vectors of a 2-input cell, compares nq against TRUTH,
// and reports a saturating error count plus a sticky per-vector fail mask.
module gate2_sweep_checker #(
  parameter logic [3:0]  TRUTH  = 4'b0001,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LOOPS  = 1
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       nq,
  output logic       i0,
  output logic       i1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_v;
  logic [3:0] r_hold;
  logic [7:0] r_loop;
  logic [7:0] r_err;
  logic [3:0] r_fail;
  logic       r_pass;

  logic       w_mis;
  logic       w_last_vec;
  logic       w_last_loop;
  logic [7:0] w_err_nxt;

  assign w_mis       = (r_state == SAMPLE) && (nq != TRUTH[r_v]);
  assign w_last_vec  = (r_v == 2'd3);
  assign w_last_loop = (r_loop == LOOP_LAST);
  assign w_err_nxt   = (w_mis && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (r_hold == HOLD_LAST) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          w_next = IDLE;
        end else if (w_last_vec && w_last_loop) begin
          w_next = FINISH;
        end else begin
          w_next = HOLD;
        end
      end
      FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Abort drops the run but keeps the evidence gathered so far.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_v    <= 2'd0;
      r_hold <= 4'd0;
      r_loop <= 8'd0;
      r_err  <= 8'd0;
      r_fail <= 4'd0;
      r_pass <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_v    <= 2'd0;
            r_hold <= 4'd0;
            r_loop <= 8'd0;
            r_err  <= 8'd0;
            r_fail <= 4'd0;
            r_pass <= 1'b0;
          end
        end
        HOLD: begin
          if (abort) begin
            r_v    <= 2'd0;
            r_hold <= 4'd0;
            r_loop <= 8'd0;
            r_pass <= 1'b0;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            r_v    <= 2'd0;
            r_hold <= 4'd0;
            r_loop <= 8'd0;
            r_pass <= 1'b0;
          end else begin
            r_err  <= w_err_nxt;
            if (w_mis) r_fail[r_v] <= 1'b1;
            r_hold <= 4'd0;
            r_v    <= r_v + 2'd1;
            if (w_last_vec) begin
              r_loop <= r_loop + 8'd1;
              if (w_last_loop) r_pass <= (w_err_nxt == 8'd0);
            end
          end
        end
        FINISH: begin
          r_v <= 2'd0;
        end
        default: r_v <= 2'd0;
      endcase
    end
  end

  assign i0       = r_v[0];
  assign i1       = r_v[1];
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;

endmodule
